// File: rtl/gpu_block_scheduler.sv
// Kernel block scheduler: splits a launch into THREADS_PER_BLOCK-sized blocks and dispatches them
// to NUM_CORES cores, lowest free core first. Define GPU_SCHED_PERF_EN to build the launch counter.
module gpu_block_scheduler #(
  parameter int unsigned NUM_CORES         = 2,
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned THREAD_COUNT_BITS = 16,
  parameter int unsigned BLOCK_ID_BITS     = 16,
  localparam int unsigned TPB_BITS         = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [THREAD_COUNT_BITS-1:0]       thread_count,
  input  logic [NUM_CORES-1:0]               core_done,
  output logic [NUM_CORES-1:0]               core_reset,
  output logic [NUM_CORES-1:0]               core_start,
  output logic [NUM_CORES*BLOCK_ID_BITS-1:0] core_block_id,
  output logic [NUM_CORES*TPB_BITS-1:0]      core_thread_count,
  output logic                               busy,
  output logic                               done,
  output logic [31:0]                        kernel_cycles
);

  localparam int unsigned LOG_TPB  = $clog2(THREADS_PER_BLOCK);
  localparam int unsigned MAX_BITS = (THREAD_COUNT_BITS > BLOCK_ID_BITS) ? THREAD_COUNT_BITS
                                                                         : BLOCK_ID_BITS;
  localparam int unsigned REM_BITS = MAX_BITS + LOG_TPB + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  typedef enum logic [1:0] {SlotFree, SlotResetting, SlotRunning} slot_e;

  state_e                             r_state;
  slot_e                              r_slot [NUM_CORES];
  logic [NUM_CORES-1:0]               r_armed;
  logic [THREAD_COUNT_BITS-1:0]       r_tc;
  logic [BLOCK_ID_BITS-1:0]           r_total_blocks;
  logic [BLOCK_ID_BITS-1:0]           r_next_block;
  logic [BLOCK_ID_BITS-1:0]           r_blocks_done;
  logic [NUM_CORES-1:0]               r_core_reset;
  logic [NUM_CORES-1:0]               r_core_start;
  logic [NUM_CORES*BLOCK_ID_BITS-1:0] r_core_block_id;
  logic [NUM_CORES*TPB_BITS-1:0]      r_core_thread_count;
  logic                               r_busy;
  logic                               r_done;

  logic                               w_accept;
  logic [THREAD_COUNT_BITS:0]         w_tc_round;
  logic [BLOCK_ID_BITS-1:0]           w_total_blocks;
  logic                               w_dispatch_pending;
  logic [NUM_CORES-1:0]               w_grant;
  logic                               w_found;
  logic [NUM_CORES-1:0]               w_retire;
  logic [BLOCK_ID_BITS-1:0]           w_retire_cnt;
  logic [REM_BITS-1:0]                w_remaining;
  logic [TPB_BITS-1:0]                w_blk_threads;

  assign w_accept       = start && (r_state != StRun);
  // Ceiling division by a power of two: round up, then shift.
  assign w_tc_round     = {1'b0, thread_count} + (THREAD_COUNT_BITS + 1)'(THREADS_PER_BLOCK - 1);
  assign w_total_blocks = BLOCK_ID_BITS'(w_tc_round >> LOG_TPB);

  assign w_dispatch_pending = (r_state == StRun) && (r_next_block < r_total_blocks);

  assign w_remaining   = REM_BITS'(r_tc) - (REM_BITS'(r_next_block) << LOG_TPB);
  assign w_blk_threads = (w_remaining >= REM_BITS'(THREADS_PER_BLOCK)) ?
                         TPB_BITS'(THREADS_PER_BLOCK) : TPB_BITS'(w_remaining);

  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!w_found && w_dispatch_pending && (r_slot[i] == SlotFree)) begin
        w_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  // A core's done is trusted only once it has been running for a full cycle.
  always_comb begin
    w_retire     = '0;
    w_retire_cnt = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      w_retire[i]  = (r_state == StRun) && (r_slot[i] == SlotRunning) && r_armed[i] &&
                     core_done[i];
      w_retire_cnt = w_retire_cnt + BLOCK_ID_BITS'(w_retire[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state             <= StIdle;
      r_armed             <= '0;
      r_tc                <= '0;
      r_total_blocks      <= '0;
      r_next_block        <= '0;
      r_blocks_done       <= '0;
      r_core_reset        <= '0;
      r_core_start        <= '0;
      r_core_block_id     <= '0;
      r_core_thread_count <= '0;
      r_busy              <= 1'b0;
      r_done              <= 1'b0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        r_slot[i] <= SlotFree;
      end
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (w_accept) begin
            r_tc           <= thread_count;
            r_total_blocks <= w_total_blocks;
            r_next_block   <= '0;
            r_blocks_done  <= '0;
            if (thread_count == '0) begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= StRun;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end
        StRun: begin
          if (r_blocks_done == r_total_blocks) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          r_blocks_done <= r_blocks_done + w_retire_cnt;
          if (|w_grant) begin
            r_next_block <= r_next_block + BLOCK_ID_BITS'(1);
          end
        end
        default: r_state <= StIdle;
      endcase

      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        case (r_slot[i])
          SlotFree: begin
            if (w_grant[i]) begin
              r_slot[i]                                     <= SlotResetting;
              r_core_reset[i]                               <= 1'b1;
              r_core_block_id[i*BLOCK_ID_BITS +: BLOCK_ID_BITS] <= r_next_block;
              r_core_thread_count[i*TPB_BITS +: TPB_BITS]   <= w_blk_threads;
            end
          end
          SlotResetting: begin
            r_slot[i]       <= SlotRunning;
            r_core_reset[i] <= 1'b0;
            r_core_start[i] <= 1'b1;
            r_armed[i]      <= 1'b0;
          end
          SlotRunning: begin
            if (w_retire[i]) begin
              r_slot[i]       <= SlotFree;
              r_core_start[i] <= 1'b0;
              r_armed[i]      <= 1'b0;
            end else begin
              r_armed[i] <= 1'b1;
            end
          end
          default: r_slot[i] <= SlotFree;
        endcase
      end
    end
  end

  assign core_reset        = r_core_reset;
  assign core_start        = r_core_start;
  assign core_block_id     = r_core_block_id;
  assign core_thread_count = r_core_thread_count;
  assign busy              = r_busy;
  assign done              = r_done;

`ifdef GPU_SCHED_PERF_EN
  logic [31:0] r_kernel_cycles;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_kernel_cycles <= '0;
    end else if (w_accept) begin
      r_kernel_cycles <= '0;
    end else if ((r_state == StRun) && (r_kernel_cycles != 32'hFFFF_FFFF)) begin
      r_kernel_cycles <= r_kernel_cycles + 32'd1;
    end
  end

  assign kernel_cycles = r_kernel_cycles;
`else
  assign kernel_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_gpu_block_scheduler.sv
// Scoreboard bench for gpu_block_scheduler: directed launches, expected dispatch/done events queued
// up front and matched by an independent monitor.
`timescale 1ns/1ps
module tb_gpu_block_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] thread_count = '0;
  logic [1:0]  core_done = '0;
  logic [1:0]  core_reset;
  logic [1:0]  core_start;
  logic [31:0] core_block_id;
  logic [5:0]  core_thread_count;
  logic        busy;
  logic        done;
  logic [31:0] kernel_cycles;

  gpu_block_scheduler #(
    .NUM_CORES        (2),
    .THREADS_PER_BLOCK(4),
    .THREAD_COUNT_BITS(16),
    .BLOCK_ID_BITS    (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .thread_count     (thread_count),
    .core_done        (core_done),
    .core_reset       (core_reset),
    .core_start       (core_start),
    .core_block_id    (core_block_id),
    .core_thread_count(core_thread_count),
    .busy             (busy),
    .done             (done),
    .kernel_cycles    (kernel_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int core;
    int id;
    int cnt;
    int rel;
    int kc;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  launch_cyc = 0;
  int  delay [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d", name, act, act, exp);
    end
  endtask

  function automatic int kc_exp(input int rel);
`ifdef GPU_SCHED_PERF_EN
    return rel;
`else
    return 0 * rel;
`endif
  endfunction

  task automatic push_disp(input int core, input int id, input int cnt, input int rel);
    ev_t e;
    e.is_done = 1'b0; e.core = core; e.id = id; e.cnt = cnt; e.rel = rel; e.kc = 0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int rel, input int kc);
    ev_t e;
    e.is_done = 1'b1; e.core = 0; e.id = 0; e.cnt = 0; e.rel = rel; e.kc = kc;
    exp_q.push_back(e);
  endtask

  // Core model: done rises delay cycles into a run and is held until the core has been running
  // for two cycles of its next block, so a stale done overlaps the first running cycle.
  initial begin
    int cnt [2];
    cnt[0] = 0;
    cnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!reset) begin
          cnt[i] = 0;
          core_done[i] = 1'b0;
        end else if (core_start[i]) begin
          cnt[i]++;
          if (cnt[i] == 2) core_done[i] = 1'b0;
          if (cnt[i] >= delay[i]) core_done[i] = 1'b1;
        end else begin
          cnt[i] = 0;
        end
      end
    end
  end

  // Monitor: every core_reset pulse is a dispatch, every rising done is a launch completion.
  initial begin
    ev_t  e;
    logic prev_done;
    int   rel;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      rel = cyc - launch_cyc;
      for (int i = 0; i < 2; i++) begin
        if (core_reset[i] === 1'b1) begin
          if (exp_q.size() == 0 || exp_q[0].is_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_dispatch: core %0d id %0d at rel %0d, none expected", i,
                     core_block_id[i*16 +: 16], rel);
          end else begin
            e = exp_q.pop_front();
            check("dispatch_core", 64'(i), 64'(e.core));
            check("dispatch_block_id", 64'(core_block_id[i*16 +: 16]), 64'(e.id));
            check("dispatch_thread_count", 64'(core_thread_count[i*3 +: 3]), 64'(e.cnt));
            check("dispatch_cycle", 64'(rel), 64'(e.rel));
          end
        end
      end
      if (done === 1'b1 && prev_done !== 1'b1) begin
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: done rose at rel %0d, none expected", rel);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", 64'(rel), 64'(e.rel));
          check("busy_at_done", 64'(busy), 64'd0);
          check("kernel_cycles_at_done", 64'(kernel_cycles), 64'(e.kc));
        end
      end
      prev_done = done;
    end
  end

  task automatic launch(input int tc, input int d0, input int d1, input bit hold,
                        input int hold_tc);
    @(negedge clk);
    delay[0]     = d0;
    delay[1]     = d1;
    launch_cyc   = cyc + 1;
    start        = 1'b1;
    thread_count = 16'(tc);
    @(negedge clk);
    check("busy_after_accept", 64'(busy), (tc == 0) ? 64'd0 : 64'd1);
    check("done_after_accept", 64'(done), (tc == 0) ? 64'd1 : 64'd0);
    if (hold) begin
      thread_count = 16'(hold_tc);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int k = 0; k < max_cycles; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    delay[0] = 5;
    delay[1] = 5;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_core_reset", 64'(core_reset), 64'd0);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_block_id", 64'(core_block_id), 64'd0);
    check("rst_thread_count", 64'(core_thread_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_kernel_cycles", 64'(kernel_cycles), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // Zero-thread launch completes immediately without touching cores.
    push_done(0, 0);
    launch(0, 5, 5, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("zero_tc_cores_idle", 64'({core_reset, core_start}), 64'd0);
    end
    wait_drain(10);

    // tc=8: two full blocks.
    push_disp(0, 0, 4, 1);
    push_disp(1, 1, 4, 2);
    push_done(9, kc_exp(9));
    launch(8, 5, 5, 1'b0, 0);
    wait_drain(40);

    // tc=10: faster core1 retires first and takes the partial block.
    push_disp(0, 0, 4, 1);
    push_disp(1, 1, 4, 2);
    push_disp(1, 2, 2, 7);
    push_done(12, kc_exp(12));
    launch(10, 5, 3, 1'b0, 0);
    wait_drain(40);

    // tc=16: both cores retire together, then blocks 2,3 go out on consecutive cycles.
    push_disp(0, 0, 4, 1);
    push_disp(1, 1, 4, 2);
    push_disp(0, 2, 4, 9);
    push_disp(1, 3, 4, 10);
    push_done(17, kc_exp(17));
    launch(16, 6, 5, 1'b0, 0);
    wait_drain(40);

    // tc=6 with a second start (tc=12) during RUN that must be ignored.
    push_disp(0, 0, 4, 1);
    push_disp(1, 1, 2, 2);
    push_done(9, kc_exp(9));
    launch(6, 5, 5, 1'b1, 12);
    wait_drain(40);

    // tc=4, core done after 10 cycles; counter must freeze in DONE.
    push_disp(0, 0, 4, 1);
    push_done(13, kc_exp(13));
    launch(4, 10, 10, 1'b0, 0);
    wait_drain(40);
    repeat (3) @(negedge clk);
    check("kernel_cycles_frozen", 64'(kernel_cycles), 64'(kc_exp(13)));
    check("done_held", 64'(done), 64'd1);
    check("busy_low_in_done", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a launch.
    push_disp(0, 0, 4, 1);
    push_disp(1, 1, 4, 2);
    launch(8, 5, 5, 1'b0, 0);
    repeat (4) @(negedge clk);
    check("both_running_before_reset", 64'(core_start), 64'd3);
    #2 reset = 1'b0;
    #1;
    check("async_core_reset", 64'(core_reset), 64'd0);
    check("async_core_start", 64'(core_start), 64'd0);
    check("async_block_id", 64'(core_block_id), 64'd0);
    check("async_thread_count", 64'(core_thread_count), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_done", 64'(done), 64'd0);
    check("async_kernel_cycles", 64'(kernel_cycles), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_idle", 64'({busy, done, core_reset, core_start}), 64'd0);
    check("no_pending_events", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
